mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the address width of every address port.
REQ-002 Parameter DATA_W, default 16, SHALL set the data width of every data port.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 if_req  input  1  fetch port request; held with if_addr stable until accepted.
REQ-006 if_addr  input  ADDR_W  fetch word address (program counter).
REQ-007 if_gnt  output  1  fetch accept; a transfer occurs at an edge where if_req&&if_gnt.
REQ-008 if_rdata  output  DATA_W  registered instruction word.
REQ-009 if_valid  output  1  one-cycle pulse qualifying if_rdata.
REQ-010 d_req  input  1  data port request; d_rw, d_addr, d_wdata held stable until accepted.
REQ-011 d_rw  input  1  0 = read, 1 = write.
REQ-012 d_addr  input  ADDR_W  data word address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_gnt  output  1  data accept; a transfer occurs at an edge where d_req&&d_gnt.
REQ-015 d_rdata  output  DATA_W  registered load data.
REQ-016 d_valid  output  1  one-cycle pulse: load data valid or store completed.
REQ-017 mem_addr  output  ADDR_W  address to the shared single-port RAM.
REQ-018 mem_rw  output  1  RAM write enable, 1 = write.
REQ-019 mem_in  output  DATA_W  RAM write data.
REQ-020 mem_out  input  DATA_W  RAM asynchronous read data for mem_addr.

Function
REQ-021 Two-stage pipeline SHALL be used: accept stage (combinational grant, registered capture) and ACCESS stage (one cycle driving the RAM).
REQ-022 At most one of if_gnt/d_gnt SHALL be high in any cycle; a grant SHALL only be issued to a port whose req is high.
REQ-023 Accept is unconditional: some requester SHALL be granted every cycle at least one req is high (throughput one access per cycle).
REQ-024 At an accepting edge the winner's id, rw, addr and wdata SHALL be captured into ACCESS registers and ACCESS_VLD SHALL set; otherwise ACCESS_VLD SHALL clear.
REQ-025 While ACCESS_VLD=1: mem_addr = captured addr, mem_in = captured wdata, mem_rw = 1 only for a captured data write; while ACCESS_VLD=0: mem_rw = 0, mem_addr = 0, mem_in = 0.
REQ-026 At the edge ending an ACCESS cycle, mem_out SHALL be captured into the winner's rdata register and the winner's valid SHALL pulse for exactly the following cycle.
REQ-027 Latency: request accepted at edge E -> RAM access in cycle E..E+1 -> valid high in cycle E+1..E+2.
REQ-028 Store: d_valid SHALL pulse as the completion ack; d_rdata SHALL then hold mem_out sampled that cycle (old contents at d_addr).
REQ-029 Data read of an address written in the immediately preceding ACCESS SHALL return the new value (RAM write lands at the edge ending the write cycle).
REQ-030 if_rdata/d_rdata SHALL hold their last value when their valid is low.
REQ-031 Address wrap: addresses SHALL be passed unmodified; decoding beyond RAM size belongs to the RAM.

Reset
REQ-032 While rst_n=0: ACCESS_VLD=0, if_gnt=d_gnt=0, if_valid=d_valid=0, mem_rw=0, mem_addr=0, mem_in=0, if_rdata=d_rdata=0, priority pointer = data-favoured.
REQ-033 Reset during an ACCESS cycle SHALL abort it: no RAM write, no valid pulse; an accepted but unfinished request is dropped and must be re-issued.

Configuration
REQ-034 With MEM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the port not granted last SHALL win (pointer updated on every grant); without it, d_req SHALL always beat if_req (fixed priority), and the pointer register SHALL not exist.

Verification
REQ-035 Single fetch: if_req=1, if_addr=0x0005, RAM[5]=0x2581 -> if_gnt at E, mem_addr=0x0005 next cycle, if_valid pulse with if_rdata=0x2581 at E+1.
REQ-036 Store then load: d write 0xBEEF to 0x0010, then d read 0x0010 back-to-back -> two d_gnt cycles, mem_rw=1 for first ACCESS only, second d_rdata=0xBEEF.
REQ-037 Contention: if_req and d_req held high for 4 cycles -> fixed build grants d,d,d,d; MEM_ARB_ROUND_ROBIN_EN build grants d,if,d,if.
REQ-038 Reset mid-write: d write 0x1234 to 0x0003 accepted, rst_n low during ACCESS -> mem_rw never 1, RAM[3] unchanged, d_valid stays 0.
REQ-039 Idle: no requests for 10 cycles -> gnts, valids, mem_rw stay 0 and rdata registers hold.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// shared single-port RAM. The "slave" modport is the arbiter's view; the
// "master" modport is the view of the requesters plus the RAM model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    // data port
    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    // shared RAM
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    modport slave (
        input  if_req, if_addr, d_req, d_rw, d_addr, d_wdata, mem_out,
        output if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
               mem_addr, mem_rw, mem_in
    );

    modport master (
        output if_req, if_addr, d_req, d_rw, d_addr, d_wdata, mem_out,
        input  if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
               mem_addr, mem_rw, mem_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with asynchronous read.
// Pipeline: accept stage (combinational grant, registered capture) followed
// by one ACCESS cycle driving the RAM; the RAM read data is registered into
// the winner's rdata at the end of ACCESS and its valid pulses one cycle.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for alternating priority on
// simultaneous requests; otherwise the data port always wins.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    // Everything the ACCESS cycle needs to know about the accepted request.
    typedef struct packed {
        logic              id_d;   // 1 = data port won, 0 = fetch port
        logic              rw;     // 1 = write (data port only)
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    logic              if_gnt_c;
    logic              d_gnt_c;
    logic              acc_vld_d, acc_vld_q;
    acc_t              acc_d,     acc_q;
    logic              if_valid_d, if_valid_q;
    logic              d_valid_d,  d_valid_q;
    logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
    logic [DATA_W-1:0] d_rdata_d,  d_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data port wins the next tie; reset leaves it data-favoured
    logic prio_d_d, prio_d_q;
`endif

    // Grant: only to a requesting port, never both, nothing while in reset.
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (rst_n) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (bus.d_req && bus.if_req) begin
                d_gnt_c  = prio_d_q;
                if_gnt_c = !prio_d_q;
            end else begin
                d_gnt_c  = bus.d_req;
                if_gnt_c = bus.if_req;
            end
`else
            d_gnt_c  = bus.d_req;
            if_gnt_c = bus.if_req && !bus.d_req;
`endif
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Pointer moves to the other port after every grant.
    always_comb begin
        prio_d_d = prio_d_q;
        if (d_gnt_c)
            prio_d_d = 1'b0;
        else if (if_gnt_c)
            prio_d_d = 1'b1;
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_d_q <= 1'b1;
        else
            prio_d_q <= prio_d_d;
    end
`endif

    // Accept stage: capture the winner into the ACCESS registers.
    always_comb begin
        acc_vld_d = d_gnt_c || if_gnt_c;
        acc_d     = acc_q;
        if (d_gnt_c) begin
            acc_d.id_d  = 1'b1;
            acc_d.rw    = bus.d_rw;
            acc_d.addr  = bus.d_addr;
            acc_d.wdata = bus.d_wdata;
        end else if (if_gnt_c) begin
            acc_d.id_d  = 1'b0;
            acc_d.rw    = 1'b0;
            acc_d.addr  = bus.if_addr;
            acc_d.wdata = '0;
        end
    end

    // Response stage: route RAM read data to the port that owned ACCESS.
    // A store also returns the pre-write contents as its ack data.
    always_comb begin
        if_valid_d = acc_vld_q && !acc_q.id_d;
        d_valid_d  = acc_vld_q &&  acc_q.id_d;
        if_rdata_d = if_valid_d ? bus.mem_out : if_rdata_q;
        d_rdata_d  = d_valid_d  ? bus.mem_out : d_rdata_q;
    end

    // Pipeline registers; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_vld_q  <= 1'b0;
            acc_q      <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            acc_vld_q  <= acc_vld_d;
            acc_q      <= acc_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // RAM drive is forced to zero whenever no access is in progress.
    assign bus.mem_addr = acc_vld_q ? acc_q.addr  : '0;
    assign bus.mem_in   = acc_vld_q ? acc_q.wdata : '0;
    assign bus.mem_rw   = acc_vld_q && acc_q.id_d && acc_q.rw;

    assign bus.if_gnt   = if_gnt_c;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.if_valid = if_valid_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected read data of
// each accepted request into a per-port queue; a negedge monitor pops and
// compares whenever a valid is presented. Directed checks cover grants,
// RAM drive, reset behaviour and idle hold.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM model: async read, write lands at the edge ending the write cycle
    logic [DW-1:0] ram [0:255];
    assign bus.mem_out = ram[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_rw) ram[bus.mem_addr[7:0]] <= bus.mem_in;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] q_if[$];
    logic [DW-1:0] q_d[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation of its port
    always @(negedge clk) begin
        if (bus.if_valid === 1'b1) begin
            if (q_if.size() == 0) chk("if_valid_unexpected", 32'(bus.if_valid), 32'd0);
            else chk("if_rdata", 32'(bus.if_rdata), 32'(q_if.pop_front()));
        end
        if (bus.d_valid === 1'b1) begin
            if (q_d.size() == 0) chk("d_valid_unexpected", 32'(bus.d_valid), 32'd0);
            else chk("d_rdata", 32'(bus.d_rdata), 32'(q_d.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0;  bus.d_rw = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3);
        ram[5]  = 16'h2581;
        ram[3]  = 16'h0042;
        ram[16] = 16'h0777;

        // Reset state, with both requests high to prove grants are gated
        bus.if_req = 1'b1; bus.if_addr = 16'h0005;
        bus.d_req = 1'b1;  bus.d_rw = 1'b1; bus.d_addr = 16'h0003; bus.d_wdata = 16'hFFFF;
        @(negedge clk);
        chk("rst_if_gnt",   32'(bus.if_gnt),   32'd0);
        chk("rst_d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid",  32'(bus.d_valid),  32'd0);
        chk("rst_mem_rw",   32'(bus.mem_rw),   32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_in",   32'(bus.mem_in),   32'd0);
        chk("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
        chk("rst_d_rdata",  32'(bus.d_rdata),  32'd0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();

        // Single fetch of RAM[5]
        bus.if_req = 1'b1; bus.if_addr = 16'h0005;
        q_if.push_back(16'h2581);
        @(negedge clk);
        chk("fetch_if_gnt", 32'(bus.if_gnt), 32'd1);
        chk("fetch_d_gnt",  32'(bus.d_gnt),  32'd0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("fetch_mem_addr", 32'(bus.mem_addr), 32'h5);
        chk("fetch_mem_rw",   32'(bus.mem_rw),   32'd0);
        chk("fetch_valid_early", 32'(bus.if_valid), 32'd0);
        step();
        @(negedge clk);
        chk("fetch_if_valid", 32'(bus.if_valid), 32'd1);
        step();
        @(negedge clk);
        chk("fetch_valid_pulse", 32'(bus.if_valid), 32'd0);

        // Contention: both requests held for four cycles; last grant was fetch
        step();
        bus.if_req = 1'b1; bus.if_addr = 16'h0005;
        bus.d_req = 1'b1;  bus.d_rw = 1'b0; bus.d_addr = 16'h0003;
        for (int c = 0; c < 4; c++) begin
            logic exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (c % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            if (exp_d) q_d.push_back(16'h0042);
            else       q_if.push_back(16'h2581);
            @(negedge clk);
            chk("cont_d_gnt",  32'(bus.d_gnt),  32'(exp_d));
            chk("cont_if_gnt", 32'(bus.if_gnt), 32'(!exp_d));
            step();
        end
        idle_inputs();
        repeat (3) step();

        // Store 0xBEEF to 0x10, then load it back on the next cycle
        bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'hBEEF;
        q_d.push_back(16'h0777);
        @(negedge clk);
        chk("st_d_gnt", 32'(bus.d_gnt), 32'd1);
        step();
        bus.d_rw = 1'b0; bus.d_wdata = 16'h0000;
        q_d.push_back(16'hBEEF);
        @(negedge clk);
        chk("ld_d_gnt",     32'(bus.d_gnt),    32'd1);
        chk("st_mem_rw",    32'(bus.mem_rw),   32'd1);
        chk("st_mem_addr",  32'(bus.mem_addr), 32'h10);
        chk("st_mem_in",    32'(bus.mem_in),   32'hBEEF);
        step();
        idle_inputs();
        @(negedge clk);
        chk("ld_mem_rw",   32'(bus.mem_rw),   32'd0);
        chk("ld_mem_addr", 32'(bus.mem_addr), 32'h10);
        repeat (3) step();

        // Reset asserted during the ACCESS cycle of a write
        bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = 16'h0003; bus.d_wdata = 16'h1234;
        @(negedge clk);
        chk("rw_d_gnt", 32'(bus.d_gnt), 32'd1);
        step();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_mem_rw",  32'(bus.mem_rw),  32'd0);
        chk("rw_d_valid", 32'(bus.d_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rw_d_valid2", 32'(bus.d_valid), 32'd0);
        chk("rw_d_rdata",  32'(bus.d_rdata), 32'd0);
        step();
        rst_n = 1'b1;
        chk("rw_ram3", 32'(ram[3]), 32'h0042);
        step();

        // Load known values into both rdata registers, then go idle
        bus.if_req = 1'b1; bus.if_addr = 16'h0005;
        q_if.push_back(16'h2581);
        step();
        idle_inputs();
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 16'h0003;
        q_d.push_back(16'h0042);
        step();
        idle_inputs();
        repeat (3) step();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_if_gnt",   32'(bus.if_gnt),   32'd0);
            chk("idle_d_gnt",    32'(bus.d_gnt),    32'd0);
            chk("idle_if_valid", 32'(bus.if_valid), 32'd0);
            chk("idle_d_valid",  32'(bus.d_valid),  32'd0);
            chk("idle_mem_rw",   32'(bus.mem_rw),   32'd0);
            chk("idle_if_rdata", 32'(bus.if_rdata), 32'h2581);
            chk("idle_d_rdata",  32'(bus.d_rdata),  32'h0042);
            step();
        end

        // Every expected response must have been delivered
        chk("if_queue_drained", 32'(q_if.size()), 32'd0);
        chk("d_queue_drained",  32'(q_d.size()),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
